// File: rtl/fx3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx3_pkg
//  Description : Shared state encoding, parameter defaults and helpers for the
//                FX3 thread-0 sink.
//  Revision    : 1.0 - initial release
// ============================================================================
package fx3_pkg;

    localparam int c_BUFFER_WORDS_DEFAULT     = 1024;
    localparam int c_WATERMARK_OFFSET_DEFAULT = 4;
    localparam int c_DRAIN_CYCLES_DEFAULT     = 16;
    localparam int c_DATA_WIDTH_DEFAULT       = 10;

    localparam logic [1:0] c_NOTREADY = 2'd0;
    localparam logic [1:0] c_ARMED    = 2'd1;
    localparam logic [1:0] c_FILLING  = 2'd2;
    localparam logic [1:0] c_COMMIT   = 2'd3;

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fx3_thread_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : fx3_thread_sink_if
//  Description : GPIF write port and status bundle between host and sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fx3_thread_sink_if import fx3_pkg::*; #(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT
);
    logic                  enable;
    logic                  fx3_nWrite;
    logic [DATA_WIDTH-1:0] fx3_data;
    logic                  fx3_nReady;
    logic                  fx3_th0Ready;
    logic                  fx3_th0Watermark;
    logic [15:0]           lastBufferWords;
    logic [15:0]           buffersCommitted;
    logic [15:0]           seqErrors;
    logic                  overrun;

    modport master (
        output enable, fx3_nWrite, fx3_data,
        input  fx3_nReady, fx3_th0Ready, fx3_th0Watermark,
               lastBufferWords, buffersCommitted, seqErrors, overrun
    );

    modport slave (
        input  enable, fx3_nWrite, fx3_data,
        output fx3_nReady, fx3_th0Ready, fx3_th0Watermark,
               lastBufferWords, buffersCommitted, seqErrors, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fx3_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module      : fx3_sequence_checker
//  Description : Counts breaks in an incrementing data sequence; resyncs on
//                every mismatch. The first word after reset is the reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx3_sequence_checker import fx3_pkg::*; #(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT
) (
    input  wire logic                  fx3_clock,
    input  wire logic                  fx3_nReset,
    input  wire logic                  valid,
    input  wire logic [DATA_WIDTH-1:0] data,
    output logic      [15:0]           errors
);
    localparam logic [DATA_WIDTH-1:0] c_ONE = DATA_WIDTH'(1);

    logic                  r_referenced;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [15:0]           r_errors;

    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            r_referenced <= 1'b0;
            r_expected   <= '0;
            r_errors     <= '0;
        end else if (valid) begin
            if (r_referenced && (data != r_expected)) begin
                r_errors <= satInc16(r_errors);
            end
            r_referenced <= 1'b1;
            r_expected   <= data + c_ONE;
        end
    end

    assign errors = r_errors;

endmodule
`default_nettype wire

// File: rtl/fx3_thread_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fx3_thread_sink
//  Description : FX3 thread-0 buffer sink: accepts GPIF writes into fixed-size
//                buffers, commits them and drains, with overrun/sequence checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx3_thread_sink import fx3_pkg::*; #(
    parameter int BUFFER_WORDS     = c_BUFFER_WORDS_DEFAULT,
    parameter int WATERMARK_OFFSET = c_WATERMARK_OFFSET_DEFAULT,
    parameter int DRAIN_CYCLES     = c_DRAIN_CYCLES_DEFAULT,
    parameter int DATA_WIDTH       = c_DATA_WIDTH_DEFAULT
) (
    input  wire logic         fx3_clock,
    input  wire logic         fx3_nReset,
    fx3_thread_sink_if.slave  bus
);
    localparam int c_CW  = $clog2(BUFFER_WORDS + 1);
    localparam int c_DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [c_CW-1:0]  c_FULL       = c_CW'(BUFFER_WORDS);
    localparam logic [c_CW-1:0]  c_WM         = c_CW'(WATERMARK_OFFSET);
    localparam logic [c_CW-1:0]  c_COUNT_ONE  = c_CW'(1);
    localparam logic [c_DRW-1:0] c_DRAIN_LAST = c_DRW'(DRAIN_CYCLES - 1);
    localparam logic [c_DRW-1:0] c_DRAIN_ONE  = c_DRW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_countNext;
    logic [c_DRW-1:0] r_drain;

    logic             w_write;
    logic             w_accept;
    logic             w_drop;
    logic             w_commitEntry;

    logic             r_nReady;
    logic             r_th0Ready;
    logic             r_th0Watermark;
    logic             w_nReadyNext;
    logic             w_th0ReadyNext;
    logic             w_th0WatermarkNext;

    logic [15:0]      r_lastBufferWords;
    logic [15:0]      r_buffersCommitted;
    logic             r_overrun;
    logic [15:0]      w_seqErrors;

    assign w_write = ~bus.fx3_nWrite;

    // A word is only taken while a buffer is open and has room; anything else is dropped.
    always_comb begin
        w_accept    = 1'b0;
        w_countNext = r_count;
        case (r_state)
            c_ARMED: begin
                if (w_write) begin
                    w_accept    = 1'b1;
                    w_countNext = c_COUNT_ONE;
                end
            end
            c_FILLING: begin
                if (w_write && (r_count < c_FULL)) begin
                    w_accept    = 1'b1;
                    w_countNext = r_count + c_COUNT_ONE;
                end
            end
            default: ;
        endcase
    end

    assign w_drop        = w_write & ~w_accept;
    assign w_commitEntry = (r_state == c_FILLING) && (w_nextState == c_COMMIT);

    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            r_state <= c_NOTREADY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_NOTREADY: begin
                if (bus.enable) w_nextState = c_ARMED;
            end
            c_ARMED: begin
                if (w_accept)         w_nextState = c_FILLING;
                else if (!bus.enable) w_nextState = c_NOTREADY;
            end
            c_FILLING: begin
                // Enable is ignored here: an open buffer always runs to commit.
                if ((w_accept && (w_countNext == c_FULL)) ||
                    (!r_th0Watermark && !w_write)) begin
                    w_nextState = c_COMMIT;
                end
            end
            c_COMMIT: begin
                if (r_drain == c_DRAIN_LAST) begin
                    w_nextState = bus.enable ? c_ARMED : c_NOTREADY;
                end
            end
            default: w_nextState = c_NOTREADY;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        w_nReadyNext       = 1'b1;
        w_th0ReadyNext     = 1'b0;
        w_th0WatermarkNext = 1'b0;
        case (w_nextState)
            c_ARMED: begin
                w_nReadyNext       = 1'b0;
                w_th0ReadyNext     = 1'b1;
                w_th0WatermarkNext = 1'b1;
            end
            c_FILLING: begin
                w_nReadyNext       = 1'b0;
                w_th0ReadyNext     = 1'b1;
                w_th0WatermarkNext = (c_FULL - w_countNext) > c_WM;
            end
            c_COMMIT: begin
                w_nReadyNext       = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            r_nReady           <= 1'b1;
            r_th0Ready         <= 1'b0;
            r_th0Watermark     <= 1'b0;
            r_count            <= '0;
            r_drain            <= '0;
            r_lastBufferWords  <= '0;
            r_buffersCommitted <= '0;
            r_overrun          <= 1'b0;
        end else begin
            r_nReady       <= w_nReadyNext;
            r_th0Ready     <= w_th0ReadyNext;
            r_th0Watermark <= w_th0WatermarkNext;
            r_count        <= ((w_nextState == c_FILLING) || (w_nextState == c_COMMIT))
                              ? w_countNext : '0;
            r_drain        <= ((r_state == c_COMMIT) && (w_nextState == c_COMMIT))
                              ? r_drain + c_DRAIN_ONE : '0;
            if (w_commitEntry) begin
                r_lastBufferWords  <= 16'(w_countNext);
                r_buffersCommitted <= r_buffersCommitted + 16'd1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    fx3_sequence_checker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sequenceChecker (
        .fx3_clock  (fx3_clock),
        .fx3_nReset (fx3_nReset),
        .valid      (w_accept),
        .data       (bus.fx3_data),
        .errors     (w_seqErrors)
    );

    assign bus.fx3_nReady       = r_nReady;
    assign bus.fx3_th0Ready     = r_th0Ready;
    assign bus.fx3_th0Watermark = r_th0Watermark;
    assign bus.lastBufferWords  = r_lastBufferWords;
    assign bus.buffersCommitted = r_buffersCommitted;
    assign bus.seqErrors        = w_seqErrors;
    assign bus.overrun          = r_overrun;

endmodule
`default_nettype wire
